dac_sample_shifter: RTL and testbench
=====================================

# dac_sample_shifter

Parametrised sample-granular delay stage between waveform generation and the RFSoC DAC AXI-stream words. Each DAC word carries SPW samples per channel. The block delays the sample stream by 0..SPW-1 samples using a two-word history and a registered output mux. Shift changes are requested through a handshake and applied atomically at a word boundary, with optional zero-blanking of the transition word. This removes mid-word glitches when the Ising-machine timing calibration retunes the DAC alignment.

## Interface
- SAMPLE_W, 16, bits per DAC sample
- SPW, 16, samples per word per channel; power of two, ≥2
- NUM_CH, 1, independent data channels sharing valid and shift
- BLANK_ON_CHANGE, 1, 1 = emit an all-zero word when the applied shift differs from the current shift
- SHIFT_W, $clog2(SPW), derived; do not override
- clk  in  1  single clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  in_word holds a new word this cycle
- in_word  in  NUM_CH*SPW*SAMPLE_W  channel c at [c*SPW*SAMPLE_W +: SPW*SAMPLE_W]; sample 0 (oldest) in the LSBs
- shift_req  in  1  request a new shift; sampled only in IDLE
- shift_amt  in  SHIFT_W  requested delay in samples, captured with shift_req
- shift_ack  out  1  one-cycle pulse: pending shift now applied
- busy  out  1  high while a request is pending (FSM not IDLE)
- shift_cur  out  SHIFT_W  shift currently applied to out_word
- out_valid  out  1  out_word holds a new word
- out_word  out  NUM_CH*SPW*SAMPLE_W  shifted output, same packing as in_word

## Operation
- Stage 1 (history): on in_valid, prev <= curr and curr <= in_word; v1 <= in_valid. When in_valid is low, history holds.
- Window per channel: W[0..SPW-1] = prev, W[SPW..2SPW-1] = curr.
- Stage 2 (output, when v1 = 1): out sample j = W[SPW + j - s], where s is the shift in effect. s = 0 passes curr through unchanged. Larger s delays the stream by s samples. All channels use the same s.
- When v1 = 0, out_word holds its value and out_valid = 0.
- FSM states IDLE and PENDING:
  - IDLE: on shift_req = 1, latch pend <= shift_amt and go to PENDING.
  - PENDING: on the first cycle with v1 = 1, stage 2 uses pend for that word.
    - If BLANK_ON_CHANGE = 1 and pend ≠ shift_cur, out_word <= 0 for that one word; out_valid is still 1.
    - In the same cycle, shift_cur <= pend. Next cycle, shift_ack = 1 and the FSM returns to IDLE.
- shift_req while in PENDING is ignored; no queueing.
- A request equal to shift_cur still completes the handshake; no blanking occurs.
- Arithmetic: the index SPW + j - s lies in [1, 2SPW-1] for all legal s, so it never wraps. shift_amt covers only 0..SPW-1, so every value is legal.

## Timing
- Reset values:
  - prev, curr, out_word = 0
  - v1, out_valid, shift_ack, busy = 0
  - shift_cur = 0, pend = 0, FSM = IDLE
- Reset mid-PENDING discards the request; no shift_ack is issued.
- Latency: a word accepted at cycle N appears on out_word with out_valid = 1 at cycle N+2. Gaps in in_valid propagate unchanged.
- Back-to-back in_valid gives one output word per cycle.
- shift_req in IDLE at cycle N with v1 = 1 at cycle N: the request does not affect that word. It applies at the first v1 = 1 cycle ≥ N+1.
- busy = 1 from cycle N+1 through the shift_ack cycle.
- After reset, the first output word with s > 0 has s leading zero samples, coming from the zeroed prev.

## Test plan
- Pass-through: SPW=16, SAMPLE_W=16, NUM_CH=1; send words whose sample k carries global index k (0..63), s=0 -> out words equal in words 2 cycles later; out_valid mirrors in_valid delayed by 2.
- Fixed shift: shift_req with amt=5 before traffic; send the same stream -> first word = {0×5, 0..10}, following words continuous (word 1 starts at index 11); shift_cur=5; one shift_ack pulse.
- Blanked change: stream running at s=0, request amt=3 -> exactly one zero word (out_valid=1), then output continues delayed by 3 samples; with BLANK_ON_CHANGE=0 -> no zero word.
- Handshake edges: second shift_req while busy is ignored and shift_cur takes the first value; shift_req with in_valid idle stays PENDING, no ack, until the next word; request equal to current -> ack, no blank.
- Stalls and reset: in_valid toggled at random -> output continuity preserved across gaps; assert rst during PENDING -> all outputs 0, shift_cur=0, no ack.
- Multi-channel: NUM_CH=2, channel 1 data = channel 0 data + 1000, s=7 -> both channels shifted identically, with no cross-channel sample leakage.

Source files
------------

// File: rtl/dac_sample_shifter.sv
// Sample-granular delay stage ahead of the RFSoC DAC stream: two-word history,
// registered output mux, and a handshake that changes the shift on a word boundary.
module dac_sample_shifter #(
  parameter int SAMPLE_W        = 16,
  parameter int SPW             = 16,
  parameter int NUM_CH          = 1,
  parameter int BLANK_ON_CHANGE = 1,
  parameter int SHIFT_W         = $clog2(SPW)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           in_valid,
  input  logic [NUM_CH*SPW*SAMPLE_W-1:0] in_word,
  input  logic                           shift_req,
  input  logic [SHIFT_W-1:0]             shift_amt,
  output logic                           shift_ack,
  output logic                           busy,
  output logic [SHIFT_W-1:0]             shift_cur,
  output logic                           out_valid,
  output logic [NUM_CH*SPW*SAMPLE_W-1:0] out_word
);

  localparam int WORD_W = SPW * SAMPLE_W;
  localparam int ALL_W  = NUM_CH * WORD_W;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_PEND = 2'd1;
  localparam logic [1:0] ST_ACK  = 2'd2;

  logic [ALL_W-1:0]   prev_p1_q, curr_p1_q;
  logic               vld_p1_q;
  logic [ALL_W-1:0]   out_word_p2_q, out_word_p2_d;
  logic               vld_p2_q;
  logic [1:0]         state_q, state_d;
  logic [SHIFT_W-1:0] pend_q, pend_d;
  logic [SHIFT_W-1:0] shift_cur_q, shift_cur_d;

  logic [SHIFT_W-1:0] s_eff;
  logic               apply;
  logic               blank;
  logic [ALL_W-1:0]   shifted;

  // Window {curr, prev}; output sample j is window sample SPW + j - s.
  function automatic logic [WORD_W-1:0] shift_window(
    input logic [WORD_W-1:0]  prev,
    input logic [WORD_W-1:0]  curr,
    input logic [SHIFT_W-1:0] s
  );
    logic [2*WORD_W-1:0] win;
    win = {curr, prev};
    win = win >> ((SPW - int'(s)) * SAMPLE_W);
    return win[WORD_W-1:0];
  endfunction

  // Stage 1 boundary: two-word history per channel
  always_ff @(posedge clk) begin
    if (rst) begin
      prev_p1_q <= '0;
      curr_p1_q <= '0;
      vld_p1_q  <= 1'b0;
    end else begin
      vld_p1_q <= in_valid;
      if (in_valid) begin
        prev_p1_q <= curr_p1_q;
        curr_p1_q <= in_word;
      end
    end
  end

  always_comb begin
    s_eff = (state_q == ST_PEND) ? pend_q : shift_cur_q;
    apply = (state_q == ST_PEND) && vld_p1_q;
    blank = apply && (BLANK_ON_CHANGE != 0) && (pend_q != shift_cur_q);
    shifted = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      shifted[c*WORD_W +: WORD_W] = shift_window(prev_p1_q[c*WORD_W +: WORD_W],
                                                 curr_p1_q[c*WORD_W +: WORD_W], s_eff);
    end
    out_word_p2_d = out_word_p2_q;
    if (vld_p1_q) out_word_p2_d = blank ? '0 : shifted;
  end

  always_comb begin
    state_d     = state_q;
    pend_d      = pend_q;
    shift_cur_d = shift_cur_q;
    case (state_q)
      ST_IDLE: begin
        if (shift_req) begin
          pend_d  = shift_amt;
          state_d = ST_PEND;
        end
      end
      ST_PEND: begin
        if (vld_p1_q) begin
          shift_cur_d = pend_q;
          state_d     = ST_ACK;
        end
      end
      ST_ACK:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Stage 2 boundary: registered output mux and shift control
  always_ff @(posedge clk) begin
    if (rst) begin
      out_word_p2_q <= '0;
      vld_p2_q      <= 1'b0;
      state_q       <= ST_IDLE;
      pend_q        <= '0;
      shift_cur_q   <= '0;
    end else begin
      out_word_p2_q <= out_word_p2_d;
      vld_p2_q      <= vld_p1_q;
      state_q       <= state_d;
      pend_q        <= pend_d;
      shift_cur_q   <= shift_cur_d;
    end
  end

  assign out_word  = out_word_p2_q;
  assign out_valid = vld_p2_q;
  assign shift_cur = shift_cur_q;
  assign shift_ack = (state_q == ST_ACK);
  assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_dac_sample_shifter.sv
// Directed bench: a vector table drives the single-channel blanking instance,
// a hand sequence drives a two-channel non-blanking instance.
module tb_dac_sample_shifter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst0, iv0, rq0;
  logic [255:0] iw0;
  logic [3:0]   ra0;
  logic         ack0, busy0, ov0;
  logic [3:0]   cur0;
  logic [255:0] ow0;

  logic         rst1, iv1, rq1;
  logic [511:0] iw1;
  logic [3:0]   ra1;
  logic         ack1, busy1, ov1;
  logic [3:0]   cur1;
  logic [511:0] ow1;

  dac_sample_shifter #(.SAMPLE_W(16), .SPW(16), .NUM_CH(1), .BLANK_ON_CHANGE(1)) dut0 (
    .clk(clk), .rst(rst0), .in_valid(iv0), .in_word(iw0), .shift_req(rq0), .shift_amt(ra0),
    .shift_ack(ack0), .busy(busy0), .shift_cur(cur0), .out_valid(ov0), .out_word(ow0));

  dac_sample_shifter #(.SAMPLE_W(16), .SPW(16), .NUM_CH(2), .BLANK_ON_CHANGE(0)) dut1 (
    .clk(clk), .rst(rst1), .in_valid(iv1), .in_word(iw1), .shift_req(rq1), .shift_amt(ra1),
    .shift_ack(ack1), .busy(busy1), .shift_cur(cur1), .out_valid(ov1), .out_word(ow1));

  int total = 0;
  int bad   = 0;

  typedef struct {
    bit rst; bit vin; int vidx; bit req; int amt;
    bit eov; bit ezero; int eidx; int ecur; bit eack; bit ebusy;
  } vec_t;

  vec_t vq[$];

  // Sample k holds global index first+k plus off; indices below zero come from zeroed history.
  function automatic logic [255:0] chan_word(input int first, input int off);
    logic [255:0] w;
    int i;
    w = '0;
    for (int k = 0; k < 16; k++) begin
      i = first + k;
      if (i >= 0) w[k*16 +: 16] = 16'(i + off);
    end
    return w;
  endfunction

  function automatic logic [511:0] w2(input int first);
    return {chan_word(first, 1000), chan_word(first, 0)};
  endfunction

  function automatic vec_t mk(input bit rst, input bit vin, input int vidx, input bit req,
                              input int amt, input bit eov, input bit ezero, input int eidx,
                              input int ecur, input bit eack, input bit ebusy);
    vec_t v;
    v.rst = rst; v.vin = vin; v.vidx = vidx; v.req = req; v.amt = amt;
    v.eov = eov; v.ezero = ezero; v.eidx = eidx; v.ecur = ecur; v.eack = eack; v.ebusy = ebusy;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [255:0] ew;
    rst0 = 1'b1; iv0 = 1'b0; iw0 = '0; rq0 = 1'b0; ra0 = '0;
    rst1 = 1'b1; iv1 = 1'b0; iw1 = '0; rq1 = 1'b0; ra1 = '0;

    // reset, then pass-through at s=0
    vq.push_back(mk(1,0,0,  0,0, 0,1,0,  0,0,0));
    vq.push_back(mk(1,1,0,  1,4, 0,1,0,  0,0,0));
    vq.push_back(mk(0,1,0,  0,0, 0,1,0,  0,0,0));
    vq.push_back(mk(0,1,16, 0,0, 1,0,0,  0,0,0));
    vq.push_back(mk(0,1,32, 0,0, 1,0,16, 0,0,0));
    vq.push_back(mk(0,1,48, 0,0, 1,0,32, 0,0,0));
    vq.push_back(mk(0,0,0,  0,0, 1,0,48, 0,0,0));
    vq.push_back(mk(0,0,0,  0,0, 0,0,48, 0,0,0));
    // change 0->3: one blanked word, then delayed by 3
    vq.push_back(mk(0,1,64, 1,3, 0,0,48, 0,0,1));
    vq.push_back(mk(0,1,80, 0,0, 1,1,0,  3,1,1));
    vq.push_back(mk(0,0,0,  0,0, 1,0,77, 3,0,0));
    vq.push_back(mk(0,0,0,  0,0, 0,0,77, 3,0,0));
    // request while a word is in stage 2; second request while busy ignored
    vq.push_back(mk(0,1,96, 0,0, 0,0,77, 3,0,0));
    vq.push_back(mk(0,1,112,1,5, 1,0,93, 3,0,1));
    vq.push_back(mk(0,1,128,1,9, 1,1,0,  5,1,1));
    vq.push_back(mk(0,0,0,  1,9, 1,0,123,5,0,0));
    vq.push_back(mk(0,0,0,  0,0, 0,0,123,5,0,0));
    // request equal to current with no traffic: waits, then acks without blanking
    vq.push_back(mk(0,0,0,  1,5, 0,0,123,5,0,1));
    vq.push_back(mk(0,0,0,  0,0, 0,0,123,5,0,1));
    vq.push_back(mk(0,0,0,  0,0, 0,0,123,5,0,1));
    vq.push_back(mk(0,1,144,0,0, 0,0,123,5,0,1));
    vq.push_back(mk(0,1,160,0,0, 1,0,139,5,1,1));
    vq.push_back(mk(0,0,0,  0,0, 1,0,155,5,0,0));
    vq.push_back(mk(0,0,0,  0,0, 0,0,155,5,0,0));
    // gaps in in_valid keep the stream continuous
    vq.push_back(mk(0,1,176,0,0, 0,0,155,5,0,0));
    vq.push_back(mk(0,0,0,  0,0, 1,0,171,5,0,0));
    vq.push_back(mk(0,1,192,0,0, 0,0,171,5,0,0));
    vq.push_back(mk(0,1,208,0,0, 1,0,187,5,0,0));
    vq.push_back(mk(0,0,0,  0,0, 1,0,203,5,0,0));
    vq.push_back(mk(0,0,0,  0,0, 0,0,203,5,0,0));
    vq.push_back(mk(0,1,224,0,0, 0,0,203,5,0,0));
    vq.push_back(mk(0,0,0,  0,0, 1,0,219,5,0,0));
    // reset while pending: request dropped, no ack
    vq.push_back(mk(0,0,0,  1,2, 0,0,219,5,0,1));
    vq.push_back(mk(1,0,0,  0,0, 0,1,0,  0,0,0));
    vq.push_back(mk(0,0,0,  0,0, 0,1,0,  0,0,0));
    // shift 5 from reset with blanking enabled
    vq.push_back(mk(0,0,0,  1,5, 0,1,0,  0,0,1));
    vq.push_back(mk(0,1,0,  0,0, 0,1,0,  0,0,1));
    vq.push_back(mk(0,1,16, 0,0, 1,1,0,  5,1,1));
    vq.push_back(mk(0,1,32, 0,0, 1,0,11, 5,0,0));
    vq.push_back(mk(0,0,0,  0,0, 1,0,27, 5,0,0));
    vq.push_back(mk(0,0,0,  0,0, 0,0,27, 5,0,0));

    for (int r = 0; r < vq.size(); r++) begin
      rst0 = vq[r].rst;
      iv0  = vq[r].vin;
      iw0  = vq[r].vin ? chan_word(vq[r].vidx, 0) : chan_word(30000, 0);
      rq0  = vq[r].req;
      ra0  = 4'(vq[r].amt);
      step();
      ew = vq[r].ezero ? 256'd0 : chan_word(vq[r].eidx, 0);
      chk($sformatf("r%0d out_valid", r), 512'(ov0), 512'(vq[r].eov));
      chk($sformatf("r%0d out_word", r), 512'(ow0), 512'(ew));
      chk($sformatf("r%0d shift_cur", r), 512'(cur0), 512'(vq[r].ecur));
      chk($sformatf("r%0d shift_ack", r), 512'(ack0), 512'(vq[r].eack));
      chk($sformatf("r%0d busy", r), 512'(busy0), 512'(vq[r].ebusy));
    end
    rst0 = 1'b0; iv0 = 1'b0; rq0 = 1'b0;

    // two channels, s=7 from reset, then 7->3 without blanking
    step();
    chk("mc reset out_valid", 512'(ov1), 512'(0));
    chk("mc reset out_word", ow1, 512'd0);
    chk("mc reset busy", 512'(busy1), 512'(0));
    rst1 = 1'b0; rq1 = 1'b1; ra1 = 4'd7; iv1 = 1'b0; iw1 = w2(20000);
    step();
    chk("mc req busy", 512'(busy1), 512'(1));
    chk("mc req shift_cur", 512'(cur1), 512'(0));
    rq1 = 1'b0; iv1 = 1'b1; iw1 = w2(0);
    step();
    chk("mc w0 out_valid", 512'(ov1), 512'(0));
    iw1 = w2(16);
    step();
    chk("mc first word", ow1, w2(-7));
    chk("mc first ack", 512'(ack1), 512'(1));
    chk("mc first shift_cur", 512'(cur1), 512'(7));
    iw1 = w2(32);
    step();
    chk("mc second word", ow1, w2(9));
    chk("mc second busy", 512'(busy1), 512'(0));
    iw1 = w2(48); rq1 = 1'b1; ra1 = 4'd3;
    step();
    chk("mc pre-change word", ow1, w2(25));
    chk("mc pre-change busy", 512'(busy1), 512'(1));
    rq1 = 1'b0; iv1 = 1'b0; iw1 = w2(20000);
    step();
    chk("mc change out_valid", 512'(ov1), 512'(1));
    chk("mc change word", ow1, w2(45));
    chk("mc change ack", 512'(ack1), 512'(1));
    chk("mc change shift_cur", 512'(cur1), 512'(3));
    step();
    chk("mc hold out_valid", 512'(ov1), 512'(0));
    chk("mc hold word", ow1, w2(45));
    chk("mc hold busy", 512'(busy1), 512'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
